// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed, big-endian, word-wide data memory.
// Sub-word stores are done as read-modify-write; bad requests fault without a memory access.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 184
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        DR,
  output logic        DW,
  input  logic [31:0] MemReadData,
  output logic [31:0] LoadData,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_CAP = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [1:0]          off_q;
  logic [HALF_W-1:0]   sdata_q;

  logic                misaligned_c;
  logic                out_of_range_c;
  logic                req_fault_c;
  logic                cap_is_load_c;
  logic [BYTE_W-1:0]   byte_c;
  logic [HALF_W-1:0]   half_c;
  logic [XLEN-1:0]     load_c;
  logic [XLEN-1:0]     merge_c;

  // Request screening on the incoming (not yet latched) request.
  always_comb begin
    misaligned_c = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned_c = Addr[0];
      OP_LW, OP_SW:         misaligned_c = (Addr[1:0] != 2'b00);
      default:              misaligned_c = 1'b0;
    endcase
    out_of_range_c = (Addr >= XLEN'(MEM_BYTES));
    req_fault_c    = misaligned_c | out_of_range_c;
  end

  // Lane select and extension of the returned word (byte 0 is the MSB lane).
  always_comb begin
    byte_c = MemReadData[31:24];
    case (off_q)
      2'd0:    byte_c = MemReadData[31:24];
      2'd1:    byte_c = MemReadData[23:16];
      2'd2:    byte_c = MemReadData[15:8];
      default: byte_c = MemReadData[7:0];
    endcase
    half_c = off_q[1] ? MemReadData[15:0] : MemReadData[31:16];

    cap_is_load_c = 1'b1;
    load_c        = MemReadData;
    case (op_q)
      OP_LB:   load_c = {{(XLEN-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      OP_LBU:  load_c = {{(XLEN-BYTE_W){1'b0}}, byte_c};
      OP_LH:   load_c = {{(XLEN-HALF_W){half_c[HALF_W-1]}}, half_c};
      OP_LHU:  load_c = {{(XLEN-HALF_W){1'b0}}, half_c};
      OP_LW:   load_c = MemReadData;
      default: cap_is_load_c = 1'b0;
    endcase
  end

  // Replace only the addressed lane of the read word for SB/SH.
  always_comb begin
    merge_c = MemReadData;
    if (op_q == OP_SB) begin
      case (off_q)
        2'd0:    merge_c[31:24] = sdata_q[BYTE_W-1:0];
        2'd1:    merge_c[23:16] = sdata_q[BYTE_W-1:0];
        2'd2:    merge_c[15:8]  = sdata_q[BYTE_W-1:0];
        default: merge_c[7:0]   = sdata_q[BYTE_W-1:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (off_q[1]) merge_c[15:0]  = sdata_q;
      else          merge_c[31:16] = sdata_q;
    end
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      op_q         <= '0;
      off_q        <= '0;
      sdata_q      <= '0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      LoadData     <= '0;
      DR           <= 1'b0;
      DW           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      DR   <= 1'b0;
      DW   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            off_q   <= Addr[1:0];
            sdata_q <= StoreData[HALF_W-1:0];
            MemAddr <= {Addr[XLEN-1:2], 2'b00};
            busy    <= 1'b1;
            if (req_fault_c) begin
              state <= S_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (op == OP_SW) begin
              state        <= S_WR;
              DW           <= 1'b1;
              MemWriteData <= StoreData;
            end else begin
              state <= S_RD_REQ;
              DR    <= 1'b1;
            end
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          if (cap_is_load_c) begin
            LoadData <= load_c;
            state    <= S_DONE;
            done     <= 1'b1;
          end else begin
            MemWriteData <= merge_c;
            state        <= S_WR;
            DW           <= 1'b1;
          end
        end
        S_WR: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          fault <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: converts processor load/store requests into word-wide DR/DW accesses on the byte-addressed, big-endian data memory.
- Supports LB, LBU, LH, LHU, LW, SB, SH and SW.
- Sub-word stores use a read-modify-write sequence.
- Sits between the main control FSM/datapath and the data memory. It reports completion with a one-cycle done pulse and flags misaligned or out-of-range requests without touching memory.

Parameters:
- MEM_BYTES, 184, size of data memory in bytes; must be a multiple of 4. Any byte address >= MEM_BYTES faults.

Ports:
- CLK  input  1  clock, all state changes on posedge.
- RST  input  1  reset, synchronous, active-high.
- start  input  1  request strobe, sampled only in IDLE.
- op  input  3  operation code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 SB, 111 SH, 011 SW.
- Addr  input  32  byte address of the request.
- StoreData  input  32  store source; SB uses [7:0], SH uses [15:0].
- MemAddr  output  32  word address to memory, always {Addr[31:2],2'b00}.
- MemWriteData  output  32  word to memory.
- DR  output  1  memory read control.
- DW  output  1  memory write control.
- MemReadData  input  32  word returned by memory; valid the cycle after a DR cycle.
- LoadData  output  32  extended load result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  held with done; 1 = misaligned or out of range, no access made.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state IDLE; DR, DW, done, fault, busy = 0; LoadData, MemAddr, MemWriteData = 0.
- Request latch: in IDLE with start=1, latch op, Addr and StoreData. start is ignored in every other state.
- Fault check, evaluated at latch:
  - Misaligned: LH/LHU/SH with Addr[0]=1, or LW/SW with Addr[1:0]!=0.
  - Out of range: Addr >= MEM_BYTES.
  - On fault: next state DONE with fault=1; DR and DW are never asserted; LoadData is unchanged.
- States and transitions:
  - IDLE -> RD_REQ for loads, SB and SH.
  - IDLE -> WR for SW.
  - IDLE -> DONE on fault.
  - RD_REQ: DR=1 for exactly this cycle; MemAddr driven. -> RD_CAP.
  - RD_CAP: MemReadData valid. For loads, register LoadData and go to DONE. For SB/SH, register the merged word into the write buffer and go to WR.
  - WR: DW=1 for exactly this cycle; MemWriteData = buffer (SW: latched StoreData). -> DONE.
  - DONE: done=1 for one cycle, fault per check. -> IDLE.
- Byte lanes (big-endian, Addr[1:0]):
  - Byte 0 = [31:24], byte 1 = [23:16], byte 2 = [15:8], byte 3 = [7:0].
  - Halfword offset 0 = [31:16], offset 2 = [15:0].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Merge: SB/SH replace only the addressed lane in the read word; all other bytes are preserved.
- Latency, counted from the start-sampling edge to the cycle done is high:
  - Loads: 3 cycles.
  - SB/SH: 4 cycles.
  - SW: 2 cycles.
  - Fault: 1 cycle.
- DR and DW are never high together. Each is high at most once per request.
- Back-to-back requests: a start asserted in the DONE cycle is ignored. The next request is accepted in the following IDLE cycle.
- Reset mid-operation:
  - RST in RD_REQ or RD_CAP aborts the request; no DW is issued and memory is untouched.
  - RST in WR: the write at that edge occurs. DW and all outputs are 0 from the next cycle.
  - No done pulse is produced for an aborted request.
- LoadData holds its value between loads. Stores do not modify it.

Test Plan:
- LW aligned: memory[8..11]=12 34 56 78; op=LW, Addr=8 -> DR pulse one cycle, MemAddr=8, done 3 cycles after start, LoadData=0x12345678, DW never high.
- LB/LBU sign: memory[13]=0x80; LB Addr=13 -> LoadData=0xFFFFFF80; LBU Addr=13 -> 0x00000080. LH Addr=14 with bytes 0xFF,0xFE -> 0xFFFFFFFE.
- SB read-modify-write: word at 16 = 0xAABBCCDD; SB Addr=18, StoreData=0x11 -> DR then DW, MemWriteData=0xAABB11DD, done 4 cycles after start. SH Addr=16, StoreData=0x5566 -> 0x5566CCDD.
- SW: Addr=20, StoreData=0xDEADBEEF -> no DR, one DW, MemWriteData=0xDEADBEEF, done 2 cycles after start; a following LW Addr=20 returns 0xDEADBEEF.
- Faults: LW Addr=6, SH Addr=3, LB Addr=184 -> each gives done with fault=1 one cycle after start, DR=DW=0 throughout, LoadData unchanged.
- Reset/overlap: SB started, RST asserted in RD_CAP -> DW never asserted, memory word unchanged, busy=0 next cycle. A start pulse asserted while busy -> ignored, exactly one done pulse produced.
